eth_tx_mem_ctrl: RTL and testbench
==================================

Name: eth_tx_mem_ctrl

Overview:
- Downstream consumer of the AHB/MCI bridge's TX-memory path.
- Holds two ping-pong TX frame buffers that the bridge writes through tx_mem_wr/tx_mem_wr_addr/tx_mem_wr_data.
- Starts a transfer when the bridge arms a buffer via mci_ctrl, and streams the frame bytewise to the MAC transmit core.
- On completion it returns a clear pulse and a status word to the bridge.

Parameters:
- BUF_AW, 8, word-address width of one buffer (256 x 32-bit words per buffer).
- LEN_W, 11, width of the byte-length field in header word.
- MAX_LEN, 1020, largest legal frame length in bytes; must be <= (2^BUF_AW - 1) * 4.

Ports:
- clk_app_i  in  1  application clock; the only clock.
- rst_clk_app  in  1  asynchronous, active-high reset.
- tx_mem_wr  in  1  write strobe from bridge.
- tx_mem_wr_addr  in  BUF_AW+1  word address; MSB selects buffer 0/1.
- tx_mem_wr_data  in  32  write data.
- mci_ctrl  in  8  bridge control; [2] = buffer 0 armed, [3] = buffer 1 armed; other bits ignored.
- tx_mem_0_clr  out  1  one-cycle pulse: buffer 0 released.
- tx_mem_1_clr  out  1  one-cycle pulse: buffer 1 released.
- tx_stat  out  6  status of last finished buffer.
- tx_stat_val_o  out  1  one-cycle pulse qualifying tx_stat.
- tx_data_o  out  8  frame byte to MAC.
- tx_val_o  out  1  byte valid.
- tx_sof_o  out  1  first byte of frame (qualified by tx_val_o).
- tx_eof_o  out  1  last byte of frame (qualified by tx_val_o).
- tx_rdy_i  in  1  MAC accepts byte when tx_val_o & tx_rdy_i.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; served flags 0; preference pointer = buffer 0. RAM contents are not reset.
- RAM: 2 x 2^BUF_AW x 32, simple dual-port, 1-cycle read latency. Writes occur on any cycle with tx_mem_wr=1, including into a buffer being transmitted (not blocked; software error).
- Buffer layout:
  - Word 0 = header; bits[LEN_W-1:0] = length L in bytes.
  - Words 1..ceil(L/4) = payload. Byte k of the frame is word 1+k/4, bits [8*(k%4)+7 : 8*(k%4)].
- Served flags:
  - served[b] is set when clr pulse b is issued.
  - served[b] is cleared when mci_ctrl[2+b] is sampled 0.
  - Buffer b is eligible when mci_ctrl[2+b]=1 and served[b]=0. This blocks retrigger during the bridge's multi-cycle clear synchronisation.
- Arbitration: if both buffers are eligible in IDLE, pick the preferred one. After finishing buffer b, the preference becomes 1-b.
- FSM states: IDLE, HDR, CHK, SEND, DONE.
  - IDLE: eligible buffer found at cycle T -> latch buffer id, issue header read, go HDR.
  - HDR (T+1): header data available; go CHK.
  - CHK (T+2):
    - L==0 or L>MAX_LEN -> go DONE with error.
    - Otherwise issue read of word 1; go SEND.
  - SEND:
    - tx_val_o rises at T+3 with tx_sof_o=1 and byte 0.
    - Next word read is issued when byte 0 of the current word is accepted. With tx_rdy_i held 1 the stream is gapless (1 byte/cycle) from sof to eof.
    - While tx_val_o=1 and tx_rdy_i=0, tx_data_o/sof/eof are held stable.
    - tx_eof_o=1 on byte L-1. When it is accepted, go DONE; tx_val_o drops the next cycle.
    - Unused bytes of the last word are never presented.
  - DONE (1 cycle):
    - Pulse tx_mem_<b>_clr and tx_stat_val_o; set served[b]; return to IDLE.
    - The next frame can start in the cycle after DONE.
- tx_stat encoding:
  - [0] sent OK.
  - [1] length error (frame dropped, nothing streamed).
  - [2] buffer id.
  - [5:3] = 0.
  - Held until the next tx_stat_val_o.
- tx_sof_o and tx_eof_o are both 1 on the single byte when L==1.
- Arming bit drop mid-frame: ignored; the frame completes.
- Reset mid-frame: outputs drop asynchronously; no clr or stat is issued. After reset a still-armed buffer is retransmitted from the start.

Test Plan:
- Write buffer 0 with header L=6, words 0x44332211, 0x00006655; raise mci_ctrl[2]; hold tx_rdy_i=1.
  - Required: bytes 11 22 33 44 55 66 on consecutive cycles; sof on 11, eof on 66.
  - Required: tx_mem_0_clr pulses; tx_stat=6'b000001.
- Same frame with tx_rdy_i toggling 1/0 every cycle.
  - Required: identical byte sequence; outputs stable in every stalled cycle; exactly one clr.
- Arm both buffers in the same cycle from reset (buffer 1 L=1, byte 0xA5).
  - Required: buffer 0 sent first, then buffer 1 as a single byte with sof=eof=1.
  - Required: tx_stat after buffer 1 = 6'b000101.
- Header L=0, then a separate run with L=1021 on buffer 1.
  - Required: no tx_val_o; tx_mem_1_clr and tx_stat_val_o pulse; tx_stat=6'b000110.
- Keep mci_ctrl[2] high for 3 cycles after tx_mem_0_clr.
  - Required: no second transmission.
  - Lower the bit, then re-raise it: frame is resent.
- Assert rst_clk_app during byte 3 of a 64-byte frame while the buffer stays armed.
  - Required: tx_val_o=0 immediately; no clr pulse; after release the frame restarts with sof and byte 0.

Source files
------------

// File: rtl/eth_tx_mem_ctrl.sv
`default_nettype none
// eth_tx_mem_ctrl: two ping-pong TX frame buffers streamed bytewise to the MAC core.
// Revision 1.0
module eth_tx_mem_ctrl #(
  parameter int BUF_AW  = 8,
  parameter int LEN_W   = 11,
  parameter int MAX_LEN = 1020
) (
  input  logic              clk_app_i,
  input  logic              rst_clk_app,
  input  logic              tx_mem_wr,
  input  logic [BUF_AW:0]   tx_mem_wr_addr,
  input  logic [31:0]       tx_mem_wr_data,
  input  logic [7:0]        mci_ctrl,
  output logic              tx_mem_0_clr,
  output logic              tx_mem_1_clr,
  output logic [5:0]        tx_stat,
  output logic              tx_stat_val_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_val_o,
  output logic              tx_sof_o,
  output logic              tx_eof_o,
  input  logic              tx_rdy_i
);

  typedef enum logic [2:0] {IDLE, HDR, CHK, SEND, DONE} state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [0:2*(2**BUF_AW)-1];
  logic [31:0]       rd_data;
  logic [31:0]       cur_word;
  logic              rd_en;
  logic [BUF_AW:0]   rd_addr;
  logic              cur_buf;
  logic              pref;
  logic [1:0]        served;
  logic [1:0]        elig;
  logic              pick;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  byte_cnt;
  logic [BUF_AW-1:0] word_ptr;
  logic              len_err;
  logic              accept;
  logic              last_byte;
  logic              unused_ctrl;

  assign unused_ctrl = ^{mci_ctrl[7:4], mci_ctrl[1:0]};

  always_ff @(posedge clk_app_i) begin
    if (tx_mem_wr)
      mem[tx_mem_wr_addr] <= tx_mem_wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk_app_i or posedge rst_clk_app) begin
    if (rst_clk_app)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = {cur_buf, word_ptr};
    elig      = mci_ctrl[3:2] & ~served;
    pick      = (elig == 2'b11) ? pref : elig[1];
    len_err   = (len == '0) || (len > LEN_W'(MAX_LEN));
    accept    = (state == SEND) && tx_rdy_i;
    last_byte = (byte_cnt == len - LEN_W'(1));
    case (state)
      IDLE: begin
        if (|elig) begin
          rd_en     = 1'b1;
          rd_addr   = {pick, {BUF_AW{1'b0}}};
          state_nxt = HDR;
        end
      end
      HDR:  state_nxt = CHK;
      CHK: begin
        if (len_err) begin
          state_nxt = DONE;
        end else begin
          rd_en     = 1'b1;
          rd_addr   = {cur_buf, BUF_AW'(1)};
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          // Byte 0 is served straight from the read port; fetch ahead once it leaves.
          if (byte_cnt[1:0] == 2'd0) begin
            rd_en   = 1'b1;
            rd_addr = {cur_buf, word_ptr + BUF_AW'(1)};
          end
          if (last_byte)
            state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_app_i or posedge rst_clk_app) begin
    if (rst_clk_app) begin
      cur_buf  <= 1'b0;
      pref     <= 1'b0;
      served   <= 2'b00;
      len      <= '0;
      byte_cnt <= '0;
      word_ptr <= '0;
      cur_word <= '0;
      tx_stat  <= '0;
    end else begin
      served <= served & mci_ctrl[3:2];
      case (state)
        IDLE: if (|elig) cur_buf <= pick;
        HDR:  len <= rd_data[LEN_W-1:0];
        CHK: begin
          byte_cnt <= '0;
          word_ptr <= BUF_AW'(1);
          if (len_err)
            tx_stat <= {3'b000, cur_buf, 2'b10};
        end
        SEND: begin
          if (accept) begin
            byte_cnt <= byte_cnt + LEN_W'(1);
            if (byte_cnt[1:0] == 2'd0) begin
              cur_word <= rd_data;
              word_ptr <= word_ptr + BUF_AW'(1);
            end
            if (last_byte)
              tx_stat <= {3'b000, cur_buf, 2'b01};
          end
        end
        DONE: begin
          served[cur_buf] <= 1'b1;
          pref            <= ~cur_buf;
        end
        default: ;
      endcase
    end
  end

  assign tx_val_o      = (state == SEND);
  assign tx_sof_o      = tx_val_o && (byte_cnt == '0);
  assign tx_eof_o      = tx_val_o && last_byte;
  assign tx_data_o     = !tx_val_o ? 8'h00 :
                         (byte_cnt[1:0] == 2'd0) ? rd_data[7:0] :
                         cur_word[{byte_cnt[1:0], 3'b000} +: 8];
  assign tx_stat_val_o = (state == DONE);
  assign tx_mem_0_clr  = (state == DONE) && !cur_buf;
  assign tx_mem_1_clr  = (state == DONE) && cur_buf;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_mem_ctrl.sv
`default_nettype none
// tb_eth_tx_mem_ctrl: directed and randomized frames checked against a byte-array reference model.
// Revision 1.0
module tb_eth_tx_mem_ctrl;
  localparam int BUF_AW  = 8;
  localparam int LEN_W   = 11;
  localparam int MAX_LEN = 1020;

  logic              clk_app_i = 1'b0;
  logic              rst_clk_app;
  logic              tx_mem_wr;
  logic [BUF_AW:0]   tx_mem_wr_addr;
  logic [31:0]       tx_mem_wr_data;
  logic [7:0]        mci_ctrl;
  logic              tx_rdy_i;
  logic              tx_mem_0_clr, tx_mem_1_clr, tx_stat_val_o;
  logic              tx_val_o, tx_sof_o, tx_eof_o;
  logic [5:0]        tx_stat;
  logic [7:0]        tx_data_o;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] model_bytes [2][1024];
  int         model_len [2];
  logic [5:0] last_stat;

  always #5 clk_app_i = ~clk_app_i;

  eth_tx_mem_ctrl #(.BUF_AW(BUF_AW), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
    .clk_app_i      (clk_app_i),
    .rst_clk_app    (rst_clk_app),
    .tx_mem_wr      (tx_mem_wr),
    .tx_mem_wr_addr (tx_mem_wr_addr),
    .tx_mem_wr_data (tx_mem_wr_data),
    .mci_ctrl       (mci_ctrl),
    .tx_mem_0_clr   (tx_mem_0_clr),
    .tx_mem_1_clr   (tx_mem_1_clr),
    .tx_stat        (tx_stat),
    .tx_stat_val_o  (tx_stat_val_o),
    .tx_data_o      (tx_data_o),
    .tx_val_o       (tx_val_o),
    .tx_sof_o       (tx_sof_o),
    .tx_eof_o       (tx_eof_o),
    .tx_rdy_i       (tx_rdy_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_arm(input bit a0, input bit a1);
    mci_ctrl = {4'($urandom()), a1, a0, 2'($urandom())};
  endtask

  task automatic mem_write(input int b, input int w, input logic [31:0] d);
    @(negedge clk_app_i);
    tx_mem_wr      = 1'b1;
    tx_mem_wr_addr = {b[0], w[BUF_AW-1:0]};
    tx_mem_wr_data = d;
    @(negedge clk_app_i);
    tx_mem_wr      = 1'b0;
  endtask

  task automatic fill_random(input int b, input int n);
    for (int k = 0; k < n; k++) model_bytes[b][k] = 8'($urandom());
  endtask

  // Header upper bits are don't-care to the design; the model only keeps the length field.
  task automatic write_frame(input int b, input logic [31:0] hdr);
    int L;
    logic [31:0] d;
    L = int'(hdr[LEN_W-1:0]);
    model_len[b] = L;
    mem_write(b, 0, hdr);
    if (L >= 1 && L <= MAX_LEN) begin
      for (int w = 0; w < (L + 3) / 4; w++) begin
        d = {model_bytes[b][4*w+3], model_bytes[b][4*w+2], model_bytes[b][4*w+1], model_bytes[b][4*w]};
        mem_write(b, w + 1, d);
      end
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_app_i);
      check("quiet_out", 32'({tx_val_o, tx_mem_0_clr, tx_mem_1_clr, tx_stat_val_o}), 32'd0);
      check("stat_hold", 32'(tx_stat), 32'(last_stat));
    end
  endtask

  // Mode 0: always ready, 1: ready toggles each cycle, 2: random ready.
  task automatic run_frame(input int b, input int mode);
    int L, lim, idx, cyc, clr_own, clr_other, val_cyc;
    bit ok, done, stalled;
    logic [9:0] held;
    logic [5:0] exp_stat;
    L = model_len[b];
    ok = (L >= 1 && L <= MAX_LEN);
    lim = ok ? L : 0;
    exp_stat = {3'b000, b[0], !ok, ok};
    idx = 0; cyc = 0; clr_own = 0; clr_other = 0; val_cyc = 0;
    done = 1'b0; stalled = 1'b0; held = '0;
    while (!done && cyc < 5000) begin
      @(negedge clk_app_i);
      cyc++;
      if (stalled)
        check("stall_hold", 32'({tx_val_o, tx_sof_o, tx_eof_o, tx_data_o}), 32'({1'b1, held}));
      if (mode == 0)      tx_rdy_i = 1'b1;
      else if (mode == 1) tx_rdy_i = cyc[0];
      else                tx_rdy_i = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (tx_val_o) begin
        val_cyc++;
        if (tx_rdy_i) begin
          check("no_overrun", 32'(idx < lim), 32'd1);
          if (idx < lim)
            check("byte", 32'({tx_sof_o, tx_eof_o, tx_data_o}),
                  32'({idx == 0, idx == L - 1, model_bytes[b][idx]}));
          idx++;
        end else begin
          stalled = 1'b1;
          held = {tx_sof_o, tx_eof_o, tx_data_o};
        end
      end
      if ((b == 0) ? tx_mem_0_clr : tx_mem_1_clr) clr_own++;
      if ((b == 0) ? tx_mem_1_clr : tx_mem_0_clr) clr_other++;
      if (tx_stat_val_o) begin
        done = 1'b1;
        check("stat", 32'(tx_stat), 32'(exp_stat));
        last_stat = exp_stat;
      end
    end
    check("finished", 32'(done), 32'd1);
    check("byte_count", idx, lim);
    check("clr_own", clr_own, 1);
    check("clr_other", clr_other, 0);
    if (mode == 0) check("gapless", val_cyc, lim);
  endtask

  task automatic do_reset();
    @(negedge clk_app_i);
    rst_clk_app = 1'b1;
    @(negedge clk_app_i);
    check("reset_out", 32'({tx_mem_0_clr, tx_mem_1_clr, tx_stat, tx_stat_val_o,
                            tx_data_o, tx_val_o, tx_sof_o, tx_eof_o}), 32'd0);
    rst_clk_app = 1'b0;
    last_stat = '0;
  endtask

  initial begin
    int seen, cyc, b, L;
    rst_clk_app = 1'b1; tx_mem_wr = 1'b0; tx_mem_wr_addr = '0; tx_mem_wr_data = '0;
    mci_ctrl = '0; tx_rdy_i = 1'b0; last_stat = '0;
    for (int k = 0; k < 1024; k++) begin model_bytes[0][k] = '0; model_bytes[1][k] = '0; end
    do_reset();

    // Basic 6-byte frame, then armed-hold, then resend with stalls.
    for (int k = 0; k < 8; k++) model_bytes[0][k] = (k < 6) ? 8'((k + 1) * 8'h11) : 8'h00;
    write_frame(0, 32'd6);
    set_arm(1'b1, 1'b0);
    run_frame(0, 0);
    quiet(3);
    set_arm(1'b0, 1'b0);
    quiet(1);
    set_arm(1'b1, 1'b0);
    run_frame(0, 1);
    set_arm(1'b0, 1'b0);
    quiet(1);

    // Randomized frames with random backpressure.
    for (int i = 0; i < 6; i++) begin
      b = int'($urandom_range(0, 1));
      L = int'($urandom_range(1, 40));
      fill_random(b, L + 4);
      write_frame(b, ($urandom() & 32'hFFFF_F800) | 32'(L));
      set_arm(b == 0, b == 1);
      run_frame(b, 2);
      set_arm(1'b0, 1'b0);
      quiet(2);
    end

    // Largest legal frame.
    fill_random(1, MAX_LEN);
    write_frame(1, 32'(MAX_LEN));
    set_arm(1'b0, 1'b1);
    run_frame(1, 0);
    set_arm(1'b0, 1'b0);
    quiet(1);

    // Both armed together from reset: buffer 0 first, then single-byte buffer 1.
    for (int k = 0; k < 8; k++) model_bytes[0][k] = (k < 6) ? 8'((k + 1) * 8'h11) : 8'h00;
    write_frame(0, 32'd6);
    model_bytes[1][0] = 8'hA5;
    for (int k = 1; k < 4; k++) model_bytes[1][k] = 8'($urandom());
    write_frame(1, 32'd1);
    do_reset();
    set_arm(1'b1, 1'b1);
    run_frame(0, 0);
    run_frame(1, 0);
    quiet(2);
    set_arm(1'b0, 1'b0);
    quiet(1);

    // Length errors.
    write_frame(0, 32'd0);
    set_arm(1'b1, 1'b0);
    run_frame(0, 2);
    set_arm(1'b0, 1'b0);
    quiet(1);
    write_frame(1, 32'(MAX_LEN + 1));
    set_arm(1'b0, 1'b1);
    run_frame(1, 2);
    set_arm(1'b0, 1'b0);
    quiet(1);

    // Reset in the middle of a 64-byte frame while still armed.
    fill_random(0, 64);
    write_frame(0, 32'd64);
    tx_rdy_i = 1'b1;
    set_arm(1'b1, 1'b0);
    seen = 0; cyc = 0;
    while (cyc < 100) begin
      @(negedge clk_app_i);
      cyc++;
      if (tx_val_o) begin
        if (seen == 3) break;
        seen++;
      end
    end
    check("reach_byte3", 32'({tx_val_o, tx_data_o}), 32'({1'b1, model_bytes[0][3]}));
    rst_clk_app = 1'b1;
    #1;
    check("async_drop", 32'({tx_val_o, tx_mem_0_clr, tx_mem_1_clr, tx_stat_val_o}), 32'd0);
    @(negedge clk_app_i);
    rst_clk_app = 1'b0;
    last_stat = '0;
    run_frame(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
